// File: rtl/pixel_stream_pkg.sv
// Shared pixel-stream widths and packer FSM states, common to the serializer and the packer.
// Pure declarations: no latency, no flow control.
package pixel_stream_pkg;
    localparam int AXIS_WIDTH_DEF  = 512;
    localparam int PIXEL_WIDTH_DEF = 8;
    localparam int PIXELS_PER_WORD = AXIS_WIDTH_DEF / PIXEL_WIDTH_DEF;
    localparam int COUNT_W         = $clog2(PIXELS_PER_WORD);

    typedef logic [COUNT_W-1:0] count_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;
endpackage

// File: rtl/axis_out_reg.sv
// One-entry AXIS output register; a load makes the beat visible 1 cycle later.
// Holds tdata/tkeep/tlast while tvalid && !tready; out_free means a load may land this edge.
module axis_out_reg #(
    parameter int DW = 512,
    parameter int KW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic [KW-1:0] load_keep,
    input  logic          load_last,
    output logic [DW-1:0] tdata,
    output logic [KW-1:0] tkeep,
    output logic          tlast,
    output logic          tvalid,
    input  logic          tready,
    output logic          out_free
);
    assign out_free = !tvalid || tready;

    // A load on a handshake edge replaces the departing beat, giving back-to-back beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tdata  <= '0;
            tkeep  <= '0;
            tlast  <= 1'b0;
            tvalid <= 1'b0;
        end else if (load) begin
            tdata  <= load_data;
            tkeep  <= load_keep;
            tlast  <= load_last;
            tvalid <= 1'b1;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end
endmodule

// File: rtl/pixel_packer.sv
// Packs 8-bit pixels LSB-first into 512-bit AXIS beats; beat valid 1 cycle after its last pixel.
// pixel_ready drops only while a completed word waits for the output register (HOLD); PIXEL_PACKER_LAST_EN enables partial flush on pixel_last.
module pixel_packer
    import pixel_stream_pkg::*;
#(
    parameter int AXIS_WIDTH  = 512,
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PIXEL_WIDTH-1:0]  pixel_in,
    input  logic                    pixel_valid,
    output logic                    pixel_ready,
    input  logic                    pixel_last,
    output logic [AXIS_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [AXIS_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast
);
    localparam int KW = AXIS_WIDTH / 8;

    state_t                st;
    count_t                count;
    logic [AXIS_WIDTH-1:0] acc;
    logic [AXIS_WIDTH-1:0] word;
    logic [KW-1:0]         keep_new;
    logic [KW-1:0]         hold_keep;
    logic                  last_new;
    logic                  hold_last;
    logic                  accept;
    logic                  complete;
    logic                  out_free;
    logic                  load;

    assign accept = pixel_valid && pixel_ready;

`ifdef PIXEL_PACKER_LAST_EN
    logic [31:0] nbytes;
    assign complete = accept && ((count == count_t'(PIXELS_PER_WORD - 1)) || pixel_last);
    assign nbytes   = (32'(count) + 32'd1) * 32'(PIXEL_WIDTH / 8);
    assign last_new = pixel_last;
    always_comb begin
        keep_new = '0;
        for (int i = 0; i < KW; i++) begin
            keep_new[i] = (32'(i) < nbytes);
        end
    end
`else
    logic unused_last;
    assign unused_last = pixel_last;
    assign complete    = accept && (count == count_t'(PIXELS_PER_WORD - 1));
    assign keep_new    = '1;
    assign last_new    = 1'b0;
`endif

    // Slots above count are still zero because acc is cleared whenever a word leaves.
    always_comb begin
        word = acc;
        word[int'(count)*PIXEL_WIDTH +: PIXEL_WIDTH] = pixel_in;
    end

    assign load = out_free && ((st == FILL && complete) || st == HOLD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st          <= FILL;
            count       <= '0;
            acc         <= '0;
            hold_keep   <= '0;
            hold_last   <= 1'b0;
            pixel_ready <= 1'b0;
        end else begin
            case (st)
                FILL: begin
                    pixel_ready <= 1'b1;
                    if (complete) begin
                        count <= '0;
                        if (out_free) begin
                            acc <= '0;
                        end else begin
                            acc         <= word;
                            hold_keep   <= keep_new;
                            hold_last   <= last_new;
                            st          <= HOLD;
                            pixel_ready <= 1'b0;
                        end
                    end else if (accept) begin
                        acc   <= word;
                        count <= count + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_free) begin
                        acc         <= '0;
                        count       <= '0;
                        st          <= FILL;
                        pixel_ready <= 1'b1;
                    end
                end
                default: st <= FILL;
            endcase
        end
    end

    axis_out_reg #(
        .DW(AXIS_WIDTH),
        .KW(KW)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data ((st == HOLD) ? acc : word),
        .load_keep ((st == HOLD) ? hold_keep : keep_new),
        .load_last ((st == HOLD) ? hold_last : last_new),
        .tdata     (m_axis_tdata),
        .tkeep     (m_axis_tkeep),
        .tlast     (m_axis_tlast),
        .tvalid    (m_axis_tvalid),
        .tready    (m_axis_tready),
        .out_free  (out_free)
    );
endmodule
